// File: rtl/mem_stage_dmem.sv
// rtl/mem_stage_dmem.sv - MEM-stage data RAM responder: 32-bit loads/stores, 64-bit stores split into two beats
// Accesses are checked for alignment and range before touching the RAM; rejected ops pulse Addr_err.
module mem_stage_dmem #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Rt_data_MEM,
    input  logic [63:0] Rt_data64_MEM,
    output logic [31:0] Read_data_MEM,
    output logic        Read_valid,
    output logic        Stall_MEM,
    output logic        Addr_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        WR64_HI = 1'b1
    } state_t;

    state_t            state_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              stall_q;
    logic              err_q;
    logic [31:0]       hi_data_q;
    logic [ADDR_W-1:0] hi_idx_q;

    logic [31:0]       mem [DEPTH];

    logic [31:0]       idx32;
    logic [ADDR_W-1:0] idx;
    logic              word_err;
    logic              dword_err;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    // Full 32-bit index is kept so that far out-of-range addresses never alias into the RAM.
    always_comb begin
        idx32 = (Adrs_MEM - BASE_ADDR) >> 2;
    end

    assign idx       = idx32[ADDR_W-1:0];
    assign word_err  = (Adrs_MEM[1:0] != 2'b00) || (idx32 >= 32'(DEPTH));
    assign dword_err = (Adrs_MEM[2:0] != 3'b000) || ((idx32 + 32'd1) >= 32'(DEPTH));

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx;
        ram_wdata = Rt_data_MEM;
        if (state_q == WR64_HI) begin
            ram_we    = 1'b1;
            ram_waddr = hi_idx_q;
            ram_wdata = hi_data_q;
        end else if (MemWrite64) begin
            ram_we    = !dword_err;
            ram_wdata = Rt_data64_MEM[31:0];
        end else if (MemWrite) begin
            ram_we    = !word_err;
        end
    end

    // The RAM has no reset; the write is gated so nothing lands while the block is held in reset.
    always_ff @(posedge Clk) begin
        if (ram_we && Reset_n) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
            hi_data_q <= 32'h0;
            hi_idx_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemWrite64) begin
                        if (dword_err) begin
                            err_q <= 1'b1;
                        end else begin
                            hi_data_q <= Rt_data64_MEM[63:32];
                            hi_idx_q  <= idx + ADDR_W'(1);
                            stall_q   <= 1'b1;
                            state_q   <= WR64_HI;
                        end
                    end else if (MemWrite) begin
                        if (word_err) begin
                            err_q <= 1'b1;
                        end
                    end else if (MemRead) begin
                        if (word_err) begin
                            err_q <= 1'b1;
                        end else begin
                            rdata_q  <= mem[idx];
                            rvalid_q <= 1'b1;
                        end
                    end
                end
                WR64_HI: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Read_data_MEM = rdata_q;
    assign Read_valid    = rvalid_q;
    assign Stall_MEM     = stall_q;
    assign Addr_err      = err_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// tb/tb_mem_stage_dmem.sv - randomized bench for mem_stage_dmem against a behavioural memory model
module tb_mem_stage_dmem;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemWrite64 = 1'b0;
    logic [31:0] Adrs_MEM = 32'h0;
    logic [31:0] Rt_data_MEM = 32'h0;
    logic [63:0] Rt_data64_MEM = 64'h0;
    logic [31:0] Read_data_MEM;
    logic        Read_valid;
    logic        Stall_MEM;
    logic        Addr_err;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [31:0] mm [DEPTH];
    bit          pend = 1'b0;
    int unsigned pend_idx = 0;
    logic [31:0] pend_data = 32'h0;
    logic [31:0] e_rd = 32'h0;
    bit          e_rv = 1'b0;
    bit          e_stall = 1'b0;
    bit          e_err = 1'b0;
    int unsigned m_off;
    int unsigned m_wi;

    mem_stage_dmem #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemWrite64   (MemWrite64),
        .Adrs_MEM     (Adrs_MEM),
        .Rt_data_MEM  (Rt_data_MEM),
        .Rt_data64_MEM(Rt_data64_MEM),
        .Read_data_MEM(Read_data_MEM),
        .Read_valid   (Read_valid),
        .Stall_MEM    (Stall_MEM),
        .Addr_err     (Addr_err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // The model sees a 64-bit store as a low-word write plus one pending high-word write
    // that consumes the next cycle; anything requested in that cycle is dropped.
    always @(posedge Clk) begin
        if (Reset_n) begin
            m_off = Adrs_MEM - BASE;
            m_wi  = m_off / 4;
            e_rv  = 1'b0;
            e_err = 1'b0;
            if (pend) begin
                mm[pend_idx] = pend_data;
                pend    = 1'b0;
                e_stall = 1'b0;
            end else if (MemWrite64) begin
                if ((Adrs_MEM % 8) == 0 && m_wi + 1 < DEPTH) begin
                    mm[m_wi]  = Rt_data64_MEM[31:0];
                    pend      = 1'b1;
                    pend_idx  = m_wi + 1;
                    pend_data = Rt_data64_MEM[63:32];
                    e_stall   = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end else if (MemWrite) begin
                if ((Adrs_MEM % 4) == 0 && m_wi < DEPTH) mm[m_wi] = Rt_data_MEM;
                else e_err = 1'b1;
            end else if (MemRead) begin
                if ((Adrs_MEM % 4) == 0 && m_wi < DEPTH) begin
                    e_rd = mm[m_wi];
                    e_rv = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    end

    always @(negedge Reset_n) begin
        pend    = 1'b0;
        e_rd    = 32'h0;
        e_rv    = 1'b0;
        e_stall = 1'b0;
        e_err   = 1'b0;
    end

    always @(negedge Clk) begin
        if (chk_en && Reset_n) begin
            chk("read_data", Read_data_MEM, e_rd);
            chk("read_valid", Read_valid, e_rv);
            chk("stall", Stall_MEM, e_stall);
            chk("addr_err", Addr_err, e_err);
        end
    end

    task automatic op(input bit r, input bit w, input bit w64, input logic [31:0] a,
                      input logic [31:0] d, input logic [63:0] d64);
        MemRead       = r;
        MemWrite      = w;
        MemWrite64    = w64;
        Adrs_MEM      = a;
        Rt_data_MEM   = d;
        Rt_data64_MEM = d64;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, $urandom, $urandom, {$urandom, $urandom});
    endtask

    logic [31:0] ra;
    logic [31:0] saved_rd;

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_rd", Read_data_MEM, 32'h0);
        chk("reset_rv", Read_valid, 1'b0);
        chk("reset_stall", Stall_MEM, 1'b0);
        chk("reset_err", Addr_err, 1'b0);
        Reset_n = 1'b1;
        chk_en  = 1'b1;

        // 1: store then load with read-after-write
        op(0, 1, 0, 32'h10, 32'hDEADBEEF, 64'h0);
        chk("t1_stall_w", Stall_MEM, 1'b0);
        op(1, 0, 0, 32'h10, 32'h0, 64'h0);
        chk("t1_rv", Read_valid, 1'b1);
        chk("t1_rd", Read_data_MEM, 32'hDEADBEEF);
        chk("t1_stall_r", Stall_MEM, 1'b0);

        // 2: 64-bit store, read held across the stall
        op(0, 0, 1, 32'h20, 32'h0, 64'h11112222_33334444);
        chk("t2_stall", Stall_MEM, 1'b1);
        op(1, 0, 0, 32'h20, 32'h0, 64'h0);
        chk("t2_held_rv", Read_valid, 1'b0);
        chk("t2_stall_done", Stall_MEM, 1'b0);
        op(1, 0, 0, 32'h20, 32'h0, 64'h0);
        chk("t2_rd_lo", Read_data_MEM, 32'h33334444);
        chk("t2_rv_lo", Read_valid, 1'b1);
        op(1, 0, 0, 32'h24, 32'h0, 64'h0);
        chk("t2_rd_hi", Read_data_MEM, 32'h11112222);

        // 3: misaligned / out of range
        op(1, 0, 0, 32'h13, 32'h0, 64'h0);
        chk("t3_err_rd", Addr_err, 1'b1);
        chk("t3_rv", Read_valid, 1'b0);
        chk("t3_rd_hold", Read_data_MEM, 32'h11112222);
        op(0, 0, 1, 32'h24, 32'h0, 64'hCCCCCCCC_DDDDDDDD);
        chk("t3_err_w64", Addr_err, 1'b1);
        chk("t3_nostall", Stall_MEM, 1'b0);
        op(1, 0, 0, 32'h24, 32'h0, 64'h0);
        chk("t3_ram24", Read_data_MEM, 32'h11112222);
        op(0, 1, 0, DEPTH * 4, 32'h12345678, 64'h0);
        chk("t3_err_range", Addr_err, 1'b1);
        op(0, 0, 1, (DEPTH - 1) * 4, 32'h0, 64'h0);
        chk("t3_err_w64_top", Addr_err, 1'b1);

        // 4: write wins over read
        op(1, 1, 0, 32'h30, 32'h5A5A5A5A, 64'h0);
        chk("t4_rv", Read_valid, 1'b0);
        chk("t4_err", Addr_err, 1'b0);
        op(1, 0, 0, 32'h30, 32'h0, 64'h0);
        chk("t4_rd", Read_data_MEM, 32'h5A5A5A5A);

        // 5: reset during the high-word beat
        op(0, 1, 0, 32'h44, 32'h44444444, 64'h0);
        op(0, 0, 1, 32'h40, 32'h0, 64'hAAAAAAAA_BBBBBBBB);
        chk("t5_stall", Stall_MEM, 1'b1);
        MemWrite64 = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("t5_rst_stall", Stall_MEM, 1'b0);
        chk("t5_rst_rd", Read_data_MEM, 32'h0);
        chk("t5_rst_rv", Read_valid, 1'b0);
        chk("t5_rst_err", Addr_err, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        op(1, 0, 0, 32'h40, 32'h0, 64'h0);
        chk("t5_rd_lo", Read_data_MEM, 32'hBBBBBBBB);
        op(1, 0, 0, 32'h44, 32'h0, 64'h0);
        chk("t5_rd_hi", Read_data_MEM, 32'h44444444);

        // 6: back-to-back 64-bit stores
        op(0, 0, 1, 32'h50, 32'h0, 64'h01010101_02020202);
        chk("t6_stall1", Stall_MEM, 1'b1);
        op(0, 0, 1, 32'h58, 32'h0, 64'h03030303_04040404);
        chk("t6_gap", Stall_MEM, 1'b0);
        op(0, 0, 1, 32'h58, 32'h0, 64'h03030303_04040404);
        chk("t6_stall2", Stall_MEM, 1'b1);
        idle();
        chk("t6_gap2", Stall_MEM, 1'b0);
        op(1, 0, 0, 32'h50, 32'h0, 64'h0);
        chk("t6_w0", Read_data_MEM, 32'h02020202);
        op(1, 0, 0, 32'h54, 32'h0, 64'h0);
        chk("t6_w1", Read_data_MEM, 32'h01010101);
        op(1, 0, 0, 32'h58, 32'h0, 64'h0);
        chk("t6_w2", Read_data_MEM, 32'h04040404);
        op(1, 0, 0, 32'h5C, 32'h0, 64'h0);
        chk("t6_w3", Read_data_MEM, 32'h03030303);

        // Fill every word so random reads only hit known contents
        for (int i = 0; i < DEPTH; i++) begin
            op(0, 1, 0, BASE + i * 4, $urandom, 64'h0);
        end

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0: ra = $urandom;
                1: ra = BASE + DEPTH * 4 - $urandom_range(0, 16);
                2: ra = BASE + $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 7);
                3: ra = BASE + $urandom_range(0, DEPTH - 1) * 4;
                default: ra = BASE + $urandom_range(0, 63) * 4;
            endcase
            op($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               ra, $urandom, {$urandom, $urandom});
        end

        // Random reset pulse mid-run, then confirm the model and DUT still agree
        saved_rd = e_rd;
        op(0, 0, 1, 32'h60, 32'h0, {$urandom, $urandom});
        MemWrite64 = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("late_rst_rd", Read_data_MEM, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
               BASE + $urandom_range(0, 63) * 4, $urandom, {$urandom, $urandom});
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
